// File: rtl/ex_stage.sv
// ex_stage -- execute stage of a five-stage RV32I pipeline.
//
// Selects forwarded operands, runs the ALU, resolves branches and jumps
// (redirect outputs are combinational), and holds everything the MEM stage
// needs in the EX/MEM pipeline register.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   pc_e, pc_plus4_e, rd1_e, rd2_e,
//   imm_e, rd_e, f3_e               ID/EX operands, destination, funct3
//   alu_function                    ALU op from the ALU controller
//   alu_src_e                       operand B select: 0 = forwarded rs2, 1 = imm
//   reg_write_e, mem_write_e,
//   branch_e, jump_e, jalr_e,
//   result_src_e                    ID/EX control bits
//   forward_a, forward_b, result_w  operand forwarding selects and WB value
//   stall_m, flush_m                hold / bubble control for EX/MEM
//   pc_src_e, pc_target_e           fetch redirect (combinational)
//   *_m                             EX/MEM registered outputs
module ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [REGW-1:0] rd_e,
  input  logic [2:0]      f3_e,
  input  logic [2:0]      alu_function,
  input  logic            alu_src_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic [1:0]      result_src_e,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] result_w,
  input  logic            stall_m,
  input  logic            flush_m,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [REGW-1:0] rd_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            taken;

  logic [XLEN-1:0] alu_result_d,   alu_result_q;
  logic [XLEN-1:0] write_data_d,   write_data_q;
  logic [XLEN-1:0] pc_plus4_d,     pc_plus4_q;
  logic [REGW-1:0] rd_d,           rd_q;
  logic            reg_write_d,    reg_write_q;
  logic            mem_write_d,    mem_write_q;
  logic [1:0]      result_src_d,   result_src_q;

  // Operand forwarding; the MEM-stage source is the registered ALU result,
  // so back-to-back dependent ops need no stall. Select 11 falls back to
  // the register file value.
  always_comb begin
    src_a = rd1_e;
    fwd_b = rd2_e;
    case (forward_a)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_q;
      default: src_a = rd1_e;
    endcase
    case (forward_b)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = rd2_e;
    endcase
    if (alu_src_e) begin
      src_b = imm_e;
    end else begin
      src_b = fwd_b;
    end
  end

  // ALU: wrap-around arithmetic, no flags; unused encodings give zero.
  always_comb begin
    alu_result = {XLEN{1'b0}};
    case (alu_function)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b101:  alu_result = src_a ^ src_b;
      default: alu_result = {XLEN{1'b0}};
    endcase
  end

  // Branch resolution compares src_a with the forwarded rs2, never the
  // immediate, so it is independent of alu_src_e.
  always_comb begin
    taken = 1'b0;
    case (f3_e)
      3'b000:  taken = (src_a == fwd_b);
      3'b001:  taken = (src_a != fwd_b);
      3'b100:  taken = ($signed(src_a) <  $signed(fwd_b));
      3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  taken = (src_a <  fwd_b);
      3'b111:  taken = (src_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign pc_src_e    = jump_e | (branch_e & taken);
  // jalr clears bit 0 of the computed address.
  assign pc_target_e = jalr_e ? {alu_result[XLEN-1:1], 1'b0} : (pc_e + imm_e);

  // EX/MEM next state: flush beats stall, stall beats capture.
  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    if (flush_m) begin
      alu_result_d = {XLEN{1'b0}};
      write_data_d = {XLEN{1'b0}};
      pc_plus4_d   = {XLEN{1'b0}};
      rd_d         = {REGW{1'b0}};
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 2'b00;
    end else if (stall_m) begin
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      pc_plus4_d   = pc_plus4_q;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      mem_write_d  = mem_write_q;
      result_src_d = result_src_q;
    end else begin
      alu_result_d = alu_result;
      write_data_d = fwd_b;
      pc_plus4_d   = pc_plus4_e;
      rd_d         = rd_e;
      reg_write_d  = reg_write_e;
      mem_write_d  = mem_write_e;
      result_src_d = result_src_e;
    end
  end

  // EX/MEM pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= {XLEN{1'b0}};
      write_data_q <= {XLEN{1'b0}};
      pc_plus4_q   <= {XLEN{1'b0}};
      rd_q         <= {REGW{1'b0}};
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
    end
  end

  assign alu_result_m = alu_result_q;
  assign write_data_m = write_data_q;
  assign pc_plus4_m   = pc_plus4_q;
  assign rd_m         = rd_q;
  assign reg_write_m  = reg_write_q;
  assign mem_write_m  = mem_write_q;
  assign result_src_m = result_src_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: reset, ALU sweep, forwarding,
// branch/jump redirect, and EX/MEM stall/flush behaviour.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
  logic [4:0]  rd_e;
  logic [2:0]  f3_e, alu_function;
  logic        alu_src_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e;
  logic [1:0]  result_src_e, forward_a, forward_b;
  logic [31:0] result_w;
  logic        stall_m, flush_m;
  logic        pc_src_e;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;
  logic        reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;

  int checks;
  int errors;

  ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .rd_e(rd_e), .f3_e(f3_e), .alu_function(alu_function),
    .alu_src_e(alu_src_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e),
    .result_src_e(result_src_e), .forward_a(forward_a), .forward_b(forward_b),
    .result_w(result_w), .stall_m(stall_m), .flush_m(flush_m),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .pc_plus4_m(pc_plus4_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .mem_write_m(mem_write_m), .result_src_m(result_src_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with nonzero inputs present.
    rst_n = 1'b0;
    pc_e = 32'h100; pc_plus4_e = 32'h104; rd1_e = 32'd3; rd2_e = 32'd4;
    imm_e = 32'd0; rd_e = 5'd5; f3_e = 3'b010; alu_function = 3'b000;
    alu_src_e = 1'b0; reg_write_e = 1'b1; mem_write_e = 1'b1;
    branch_e = 1'b0; jump_e = 1'b0; jalr_e = 1'b0; result_src_e = 2'b10;
    forward_a = 2'b00; forward_b = 2'b00; result_w = 32'd0;
    stall_m = 1'b0; flush_m = 1'b0;
    step();
    step();
    check("rst_alu", alu_result_m, 32'h0);
    check("rst_regw", {31'd0, reg_write_m}, 32'h0);
    rst_n = 1'b1;
    step();
    check("first_add", alu_result_m, 32'd7);
    check("first_wd", write_data_m, 32'd4);
    check("first_rd", {27'd0, rd_m}, 32'd5);
    check("first_pc4", pc_plus4_m, 32'h104);
    check("first_rsrc", {30'd0, result_src_m}, 32'd2);
    check("first_memw", {31'd0, mem_write_m}, 32'd1);

    // Asynchronous reset between edges clears immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_alu", alu_result_m, 32'h0);
    check("async_wd", write_data_m, 32'h0);
    check("async_pc4", pc_plus4_m, 32'h0);
    check("async_rd", {27'd0, rd_m}, 32'h0);
    check("async_ctl", {28'd0, reg_write_m, mem_write_m, result_src_m}, 32'h0);
    rst_n = 1'b1;
    step();
    check("rel_add", alu_result_m, 32'd7);

    // ALU sweep.
    rd1_e = 32'hFFFF_FFFE; rd2_e = 32'h0000_0003;
    alu_function = 3'b000; step(); check("alu_add", alu_result_m, 32'h0000_0001);
    alu_function = 3'b001; step(); check("alu_sub", alu_result_m, 32'hFFFF_FFFB);
    alu_function = 3'b010; step(); check("alu_and", alu_result_m, 32'h0000_0002);
    alu_function = 3'b011; step(); check("alu_or",  alu_result_m, 32'hFFFF_FFFF);
    alu_function = 3'b100; step(); check("alu_slt", alu_result_m, 32'h0000_0001);
    alu_function = 3'b101; step(); check("alu_xor", alu_result_m, 32'hFFFF_FFFD);
    alu_function = 3'b110; step(); check("alu_110", alu_result_m, 32'h0);
    alu_function = 3'b111; step(); check("alu_111", alu_result_m, 32'h0);
    // slt with 3 vs -2 is false.
    rd1_e = 32'd3; rd2_e = 32'hFFFF_FFFE; alu_function = 3'b100;
    step(); check("alu_slt_f", alu_result_m, 32'h0);
    // Immediate operand; write data still takes rs2.
    rd1_e = 32'd5; rd2_e = 32'h77; imm_e = 32'h10; alu_src_e = 1'b1; alu_function = 3'b000;
    step();
    check("alu_imm", alu_result_m, 32'h15);
    check("alu_imm_wd", write_data_m, 32'h77);
    alu_src_e = 1'b0; imm_e = 32'd0;

    // Forwarding.
    rd1_e = 32'h10; rd2_e = 32'h0;
    step(); check("fwd_prep", alu_result_m, 32'h10);
    forward_a = 2'b10; forward_b = 2'b01; result_w = 32'h20;
    rd1_e = 32'h999; rd2_e = 32'h777;
    step();
    check("fwd_alu", alu_result_m, 32'h30);
    check("fwd_wd", write_data_m, 32'h20);
    forward_a = 2'b11; forward_b = 2'b11; rd1_e = 32'h5; rd2_e = 32'h6;
    step();
    check("fwd_11", alu_result_m, 32'hB);
    check("fwd_11_wd", write_data_m, 32'h6);
    forward_a = 2'b10; forward_b = 2'b00; rd2_e = 32'h1;
    step(); check("fwd_b2b", alu_result_m, 32'hC);
    forward_a = 2'b00; forward_b = 2'b10; rd1_e = 32'h100;
    step(); check("fwd_b_m", write_data_m, 32'hC);
    forward_b = 2'b00;

    // Branch and jump redirect (combinational).
    pc_e = 32'h100; imm_e = 32'h20; branch_e = 1'b1;
    rd1_e = 32'd7; rd2_e = 32'd7; alu_src_e = 1'b1;
    f3_e = 3'b000; #1;
    check("beq_src", {31'd0, pc_src_e}, 32'd1);
    check("beq_tgt", pc_target_e, 32'h120);
    f3_e = 3'b001; #1; check("bne_eq", {31'd0, pc_src_e}, 32'd0);
    f3_e = 3'b010; #1; check("f3_010", {31'd0, pc_src_e}, 32'd0);
    alu_src_e = 1'b0;
    rd1_e = 32'hFFFF_FFFF; rd2_e = 32'd1;
    f3_e = 3'b100; #1; check("blt", {31'd0, pc_src_e}, 32'd1);
    f3_e = 3'b110; #1; check("bltu", {31'd0, pc_src_e}, 32'd0);
    f3_e = 3'b101; #1; check("bge", {31'd0, pc_src_e}, 32'd0);
    f3_e = 3'b111; #1; check("bgeu", {31'd0, pc_src_e}, 32'd1);
    f3_e = 3'b001; #1; check("bne_ne", {31'd0, pc_src_e}, 32'd1);
    branch_e = 1'b0; #1; check("nobranch", {31'd0, pc_src_e}, 32'd0);
    jump_e = 1'b1; #1;
    check("jal_src", {31'd0, pc_src_e}, 32'd1);
    check("jal_tgt", pc_target_e, 32'h120);
    jalr_e = 1'b1; rd1_e = 32'h205; imm_e = 32'd0; alu_src_e = 1'b1; alu_function = 3'b000;
    #1;
    check("jalr_tgt", pc_target_e, 32'h204);
    check("jalr_src", {31'd0, pc_src_e}, 32'd1);
    jump_e = 1'b0; jalr_e = 1'b0; alu_src_e = 1'b0; f3_e = 3'b010;

    // Stall / flush.
    rd1_e = 32'h40; rd2_e = 32'h2; reg_write_e = 1'b1; mem_write_e = 1'b1;
    rd_e = 5'd7; result_src_e = 2'b01; pc_plus4_e = 32'h200;
    step(); check("pre_stall", alu_result_m, 32'h42);
    rd1_e = 32'h1000; rd_e = 5'd9; pc_plus4_e = 32'h300; stall_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_alu", alu_result_m, 32'h42);
    end
    check("stall_rd", {27'd0, rd_m}, 32'd7);
    check("stall_pc4", pc_plus4_m, 32'h200);
    check("stall_wd", write_data_m, 32'h2);
    stall_m = 1'b0; flush_m = 1'b1;
    step();
    check("flush_regw", {31'd0, reg_write_m}, 32'd0);
    check("flush_alu", alu_result_m, 32'h0);
    check("flush_memw", {31'd0, mem_write_m}, 32'd0);
    check("flush_rd", {27'd0, rd_m}, 32'd0);
    flush_m = 1'b0;
    step(); check("recap", alu_result_m, 32'h1002);
    check("recap_rd", {27'd0, rd_m}, 32'd9);
    stall_m = 1'b1; flush_m = 1'b1;
    step();
    check("both_alu", alu_result_m, 32'h0);
    check("both_regw", {31'd0, reg_write_m}, 32'd0);
    check("both_pc4", pc_plus4_m, 32'h0);

    // Reset asserted while stalled.
    flush_m = 1'b0; stall_m = 1'b0;
    step(); check("pre_rst2", alu_result_m, 32'h1002);
    stall_m = 1'b1;
    step();
    #2; rst_n = 1'b0; #1;
    check("rst_stall", alu_result_m, 32'h0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
